// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: registered N-way arbiter sharing one downstream resource among PORTS
// requesters. Supports round-robin or fixed priority, with optional grant holding until
// release by acknowledge pulse or request deassertion.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   request       per-port request level
//   acknowledge   per-port release pulse (ARB_BLOCK=1, ARB_BLOCK_ACK=1 only)
//   grant         one-hot grant, registered
//   grant_valid   high when any grant bit is set, registered
//   grant_encoded binary index of the granted port, registered (0 when no grant)
module rr_grant_arbiter #(
  parameter int unsigned PORTS                 = 4,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b1,
  parameter bit          ARB_BLOCK             = 1'b1,
  parameter bit          ARB_BLOCK_ACK         = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned EncW                 = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EncW-1:0]  grant_encoded
);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  typedef struct packed {
    logic            valid;
    logic [EncW-1:0] idx;
  } enc_t;

  // Priority encoder; tie-break direction set by ARB_LSB_HIGH_PRIORITY.
  function automatic enc_t prio_enc(input logic [PORTS-1:0] vec);
    enc_t res;
    res = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (ARB_LSB_HIGH_PRIORITY) begin
        if (vec[i] && !res.valid) begin
          res.valid = 1'b1;
          res.idx   = EncW'(i);
        end
      end else if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = EncW'(i);
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [EncW-1:0]  enc_q, enc_d;
  logic [PORTS-1:0] mask_q, mask_d;

  enc_t raw_enc;
  enc_t masked_enc;

  // Two encoders: one over all requests, one over requests still eligible this round.
  assign raw_enc    = prio_enc(request);
  assign masked_enc = prio_enc(request & mask_q);

  logic            hold;
  logic [EncW-1:0] win;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mask_d  = mask_q;
    hold    = 1'b0;
    win     = raw_enc.idx;

    if (state_q == StGranted && ARB_BLOCK) begin
      // Acknowledge wins over a still-asserted request on the granted port.
      hold = ARB_BLOCK_ACK ? !acknowledge[enc_q] : request[enc_q];
    end

    if (!hold) begin
      if (raw_enc.valid) begin
        // Empty masked vector means the round is over: fall back to the raw vector.
        if (ARB_TYPE_ROUND_ROBIN && masked_enc.valid) begin
          win = masked_enc.idx;
        end
        state_d = StGranted;
        valid_d = 1'b1;
        enc_d   = win;
        for (int i = 0; i < PORTS; i++) begin
          grant_d[i] = (i == int'(win));
          mask_d[i]  = ARB_LSB_HIGH_PRIORITY ? (i > int'(win)) : (i < int'(win));
        end
      end else begin
        state_d = StIdle;
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      valid_q <= 1'b0;
      enc_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      enc_q   <= enc_d;
      mask_q  <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst;

  // a: defaults (RR, ack blocking, MSB high)
  logic [3:0] req_a, ack_a, gnt_a;
  logic       vld_a;
  logic [1:0] enc_a;
  // b: fixed priority, blocking by request level
  logic [3:0] req_b, ack_b, gnt_b;
  logic       vld_b;
  logic [1:0] enc_b;
  // c: non-blocking RR, LSB high
  logic [3:0] req_c, ack_c, gnt_c;
  logic       vld_c;
  logic [1:0] enc_c;

  int n_checks;
  int n_pass;

  rr_grant_arbiter u_a (
    .clk          (clk),
    .rst          (rst),
    .request      (req_a),
    .acknowledge  (ack_a),
    .grant        (gnt_a),
    .grant_valid  (vld_a),
    .grant_encoded(enc_a)
  );

  rr_grant_arbiter #(
    .ARB_TYPE_ROUND_ROBIN(1'b0),
    .ARB_BLOCK_ACK       (1'b0)
  ) u_b (
    .clk          (clk),
    .rst          (rst),
    .request      (req_b),
    .acknowledge  (ack_b),
    .grant        (gnt_b),
    .grant_valid  (vld_b),
    .grant_encoded(enc_b)
  );

  rr_grant_arbiter #(
    .ARB_BLOCK            (1'b0),
    .ARB_LSB_HIGH_PRIORITY(1'b1)
  ) u_c (
    .clk          (clk),
    .rst          (rst),
    .request      (req_c),
    .acknowledge  (ack_c),
    .grant        (gnt_c),
    .grant_valid  (vld_c),
    .grant_encoded(enc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] e,
                         input logic v);
    check_eq({tag, ".grant"}, 32'(gnt_a), 32'(g));
    check_eq({tag, ".enc"}, 32'(enc_a), 32'(e));
    check_eq({tag, ".valid"}, 32'(vld_a), 32'(v));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    req_a = '0; ack_a = '0;
    req_b = '0; ack_b = '0;
    req_c = '0; ack_c = '0;
    #12;
    check_a("reset_a", 4'b0000, 2'd0, 1'b0);
    check_eq("reset_b.grant", 32'(gnt_b), 32'h0);
    check_eq("reset_c.valid", 32'(vld_c), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Default instance: hold without acknowledge
    req_a = 4'b1010;
    tick();
    check_a("first_grant", 4'b1000, 2'd3, 1'b1);
    req_a = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_no_ack", 32'(gnt_a), 32'h8);
    end

    // Acknowledge release, RR advances, then mask empties and wraps
    ack_a = 4'b1000; req_a = 4'b1010;
    tick();
    check_a("rr_next", 4'b0010, 2'd1, 1'b1);
    ack_a = 4'b0010;
    tick();
    check_a("rr_wrap", 4'b1000, 2'd3, 1'b1);
    ack_a = 4'b0000;
    tick();
    check_eq("held_after_wrap", 32'(gnt_a), 32'h8);

    // Stray acknowledge on a non-granted port
    ack_a = 4'b0001;
    tick();
    check_a("stray_ack", 4'b1000, 2'd3, 1'b1);

    // Release with no requests left -> idle
    req_a = 4'b0000; ack_a = 4'b1000;
    tick();
    check_a("to_idle", 4'b0000, 2'd0, 1'b0);
    ack_a = 4'b1111;
    tick();
    check_a("ack_in_idle", 4'b0000, 2'd0, 1'b0);
    ack_a = 4'b0000;

    // Fixed priority, released by request deassert
    req_b = 4'b1111;
    tick();
    check_eq("fp_first", 32'(gnt_b), 32'h8);
    tick();
    check_eq("fp_hold", 32'(gnt_b), 32'h8);
    req_b = 4'b0111;
    tick();
    check_eq("fp_drop3.grant", 32'(gnt_b), 32'h4);
    check_eq("fp_drop3.enc", 32'(enc_b), 32'd2);
    req_b = 4'b1111;
    tick();
    check_eq("fp_hold2", 32'(gnt_b), 32'h4);
    req_b = 4'b1011;
    tick();
    check_eq("fp_back3.grant", 32'(gnt_b), 32'h8);
    check_eq("fp_back3.enc", 32'(enc_b), 32'd3);
    req_b = 4'b0000;

    // Non-blocking RR, LSB high: 0,1,2,0,1,2
    req_c = 4'b0111;
    tick();
    check_eq("nb0.grant", 32'(gnt_c), 32'h1);
    check_eq("nb0.enc", 32'(enc_c), 32'd0);
    tick();
    check_eq("nb1.grant", 32'(gnt_c), 32'h2);
    check_eq("nb1.enc", 32'(enc_c), 32'd1);
    tick();
    check_eq("nb2.grant", 32'(gnt_c), 32'h4);
    check_eq("nb2.enc", 32'(enc_c), 32'd2);
    tick();
    check_eq("nb3.grant", 32'(gnt_c), 32'h1);
    check_eq("nb3.enc", 32'(enc_c), 32'd0);
    tick();
    check_eq("nb4.grant", 32'(gnt_c), 32'h2);
    tick();
    check_eq("nb5.grant", 32'(gnt_c), 32'h4);

    // Asynchronous reset mid-cycle while grant=0100
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst.grant", 32'(gnt_c), 32'h0);
    check_eq("async_rst.valid", 32'(vld_c), 32'h0);
    check_eq("async_rst.enc", 32'(enc_c), 32'd0);
    req_c = 4'b0100;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst.grant", 32'(gnt_c), 32'h4);
    check_eq("post_rst.enc", 32'(enc_c), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
